fpm_result_pack: RTL and testbench
==================================

# fpm_result_pack

Output stage of the floating-point multiplier pipeline. It takes the raw 48-bit mantissa product, the sign, and the biased exponent sum from the multiply stage. It normalizes, rounds, and detects overflow/underflow, then packs an IEEE-754 single-precision result. It is the counterpart of the input operand buffers: registered, two stages deep, with valid/ready backpressure toward the result consumer.

## Interface
Parameters:
- none (format fixed at binary32)

Ports:
- `clk` in 1 – single clock; all state updates on rising edge
- `rst` in 1 – asynchronous, active-high reset
- `in_valid` in 1 – product bundle valid
- `in_ready` out 1 – stage can accept the bundle this cycle
- `in_sign` in 1 – result sign (sa ^ sb)
- `in_exp` in 10 – two's-complement biased exponent sum, ea+eb-127
- `in_mant` in 48 – product of two 24-bit 1.f mantissas
- `in_zero` in 1 – either operand zero
- `in_inf` in 1 – either operand infinite
- `in_nan` in 1 – NaN operand or 0×inf
- `out_valid` out 1 – result valid
- `out_ready` in 1 – consumer accepts the result
- `out_result` out 32 – packed binary32
- `out_ovf` out 1 – result saturated to infinity by exponent overflow
- `out_unf` out 1 – result flushed to zero by exponent underflow

## Operation
- Transfer on each side occurs when valid && ready.
- **Stage S1 (registered)** computes normalize and round:
  - If `p[47]`=1: m=`p[46:24]`, g=`p[23]`, s=|`p[22:0]`, e=`in_exp`+1.
  - Else: m=`p[45:23]`, g=`p[22]`, s=|`p[21:0]`, e=`in_exp`.
  - Round up when g && (s || m[0]). This is round-to-nearest-even, subject to the macro.
  - If the round-up carries out of m (all ones), m becomes 0 and e becomes e+1.
  - All e arithmetic is 10-bit signed.
- **Stage S2 (registered)** packs with this priority:
  - `in_nan` → 0x7FC00000, flags 0.
  - `in_inf` → {sign,0xFF,0}, flags 0.
  - `in_zero` → {sign,31'b0}, flags 0.
  - e ≥ 255 → {sign,0xFF,0}, `out_ovf`=1.
  - e ≤ 0 → {sign,31'b0}, `out_unf`=1. There are no subnormals.
  - Otherwise {sign,e[7:0],m}.
- Handshake:
  - s2_adv = !s2_valid || `out_ready`.
  - s1_adv = !s1_valid || s2_adv.
  - `in_ready` = s1_adv.
- Ordering is strictly in order; there is no drop and no duplication.
- `out_result` and flags are stable while `out_valid` && !`out_ready`.
- Every output-facing register loads only on its stage advance.

## Timing
- Latency: 2 cycles from input transfer to `out_valid` when there is no stall.
- Throughput: 1 result per cycle.
- Capacity: 2 bundles in flight. With `out_ready` held low, the third bundle sees `in_ready`=0.
- `in_ready` is combinational from `out_ready` and the internal valids.
- Reset values: `out_valid`=0, `out_result`=0, `out_ovf`=0, `out_unf`=0, all internal valids 0, so `in_ready`=1 after reset.
- Reset mid-operation discards all in-flight bundles immediately (asynchronous). No partial result appears after deassertion.
- Simultaneous S2 drain and S1 fill in the same cycle is legal: the pipeline advances as a whole.

## Configuration
- `FPM_ROUND_RNE_EN` defined: round-to-nearest-even as above, including carry-out renormalization.
- Not defined: truncation. m is used unrounded, g/s are ignored, and no carry-out path exists. Overflow/underflow checks still apply to e.

## Structure
- Package `fpm_pkg` holds:
  - `FPM_BIAS`=127, `FPM_EXP_MAX`=255
  - `FPM_QNAN`=32'h7FC00000
  - typedef `fpm_s1_t` {sign, exp[9:0], mant[22:0], nan, inf, zero}
- One sub-module, `fpm_norm_round`: purely combinational normalize + round. It feeds the S1 register, keeping the handshake/pipeline logic in the top.

## Test plan
- **Basic product:** sign 0, `in_exp`=127, p=0x900000000000 (1.5×1.5) → `out_result`=0x40100000 two cycles later, flags 0.
- **Rounding (macro on):**
  - p=0x400000400000 (exp 127) → 0x3F800000 (tie to even).
  - p=0x400000C00000 → 0x3F800002.
  - p=0x7FFFFFC00000 → 0x40000000 (carry-out).
  - **Macro off:** the second case gives 0x3F800001.
- **Overflow/underflow:**
  - `in_exp`=254, p=0x800000000000 → 0x7F800000, `out_ovf`=1.
  - `in_exp`=0, sign 1, p=0x400000000000 → 0x80000000, `out_unf`=1.
- **Specials:**
  - `in_nan`=1 with `in_inf`=1 → 0x7FC00000.
  - `in_inf`, sign 1 → 0xFF800000.
  - `in_zero` → 0x00000000.
- **Backpressure:** `out_ready`=0, offer 3 back-to-back bundles → first two accepted, `in_ready`=0 on the third. Then `out_ready`=1 → all three emerge in order, one per cycle, each held stable while stalled.
- **Reset:** assert `rst` with 2 bundles in flight → `out_valid` drops immediately, `in_ready`=1 after release, and no stale result ever appears.

Source files
------------

// File: rtl/fpm_pkg.sv
// Shared constants and the S1 pipeline bundle for the binary32 multiplier
// result stage.
package fpm_pkg;

    localparam int          FPM_BIAS    = 127;
    localparam int          FPM_EXP_MAX = 255;
    localparam logic [31:0] FPM_QNAN    = 32'h7FC00000;

    typedef struct packed {
        logic               sign;
        logic signed [9:0]  exp;
        logic [22:0]        mant;
        logic               nan;
        logic               inf;
        logic               zero;
    } fpm_s1_t;

endpackage

// File: rtl/fpm_result_pack_if.sv
// Product-in / result-out handshake bundle of the multiplier output stage.
// The producer-plus-consumer side uses master; the pack stage uses slave.
interface fpm_result_pack_if;

    logic               in_valid;
    logic               in_ready;
    logic               in_sign;
    logic signed [9:0]  in_exp;
    logic [47:0]        in_mant;
    logic               in_zero;
    logic               in_inf;
    logic               in_nan;

    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_result;
    logic               out_ovf;
    logic               out_unf;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_zero, in_inf, in_nan,
        output out_ready,
        input  in_ready,
        input  out_valid, out_result, out_ovf, out_unf
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_zero, in_inf, in_nan,
        input  out_ready,
        output in_ready,
        output out_valid, out_result, out_ovf, out_unf
    );

endinterface

// File: rtl/fpm_norm_round.sv
// Combinational normalize + round of the 48-bit mantissa product.
// Build option: FPM_ROUND_RNE_EN selects round-to-nearest-even, else truncation.
module fpm_norm_round
    import fpm_pkg::*;
(
    input  logic               sign,
    input  logic signed [9:0]  exp_sum,
    input  logic [47:0]        mant_prod,
    input  logic               nan,
    input  logic               inf,
    input  logic               zero,
    output fpm_s1_t            s1
);

    function automatic logic round_inc(input logic g, input logic s, input logic lsb);
`ifdef FPM_ROUND_RNE_EN
        return g && (s || lsb);
`else
        return 1'b0;
`endif
    endfunction

    logic [22:0]        m;
    logic               g;
    logic               st;
    logic signed [9:0]  e;
    logic               inc;
    logic [23:0]        sum;

    always_comb begin
        // 1.f x 1.f lies in [1,4): the top bit picks which 23 bits form the fraction
        if (mant_prod[47]) begin
            m  = mant_prod[46:24];
            g  = mant_prod[23];
            st = |mant_prod[22:0];
            e  = exp_sum + 10'sd1;
        end else begin
            m  = mant_prod[45:23];
            g  = mant_prod[22];
            st = |mant_prod[21:0];
            e  = exp_sum;
        end

        inc = round_inc(g, st, m[0]);
        sum = {1'b0, m} + {23'b0, inc};

        s1.sign = sign;
        // an all-ones fraction rounding up becomes 1.0 x 2^(e+1)
        s1.exp  = sum[23] ? e + 10'sd1 : e;
        s1.mant = sum[22:0];
        s1.nan  = nan;
        s1.inf  = inf;
        s1.zero = zero;
    end

endmodule

// File: rtl/fpm_result_pack.sv
// Two-stage registered output stage of the FP multiplier: normalize/round, then pack.
// Build option: FPM_ROUND_RNE_EN (consumed by fpm_norm_round) enables RNE rounding.
module fpm_result_pack
    import fpm_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    fpm_result_pack_if.slave   bus
);

    localparam logic signed [9:0] EXP_MAX_S = 10'(FPM_EXP_MAX);

    // Returns {ovf, unf, result}; specials take priority over range checks.
    function automatic logic [33:0] pack_result(input fpm_s1_t s);
        logic [31:0] r;
        logic        ovf;
        logic        unf;
        ovf = 1'b0;
        unf = 1'b0;
        if (s.nan) begin
            r = FPM_QNAN;
        end else if (s.inf) begin
            r = {s.sign, 8'hFF, 23'b0};
        end else if (s.zero) begin
            r = {s.sign, 31'b0};
        end else if ($signed(s.exp) >= EXP_MAX_S) begin
            r   = {s.sign, 8'hFF, 23'b0};
            ovf = 1'b1;
        end else if ($signed(s.exp) <= 10'sd0) begin
            r   = {s.sign, 31'b0};
            unf = 1'b1;
        end else begin
            r = {s.sign, s.exp[7:0], s.mant};
        end
        return {ovf, unf, r};
    endfunction

    fpm_s1_t      norm_p0;
    fpm_s1_t      s1_p1;
    logic         vld_p1;
    logic         vld_p2;
    logic [31:0]  res_p2;
    logic         ovf_p2;
    logic         unf_p2;
    logic         s1_adv;
    logic         s2_adv;

    // ---- stage 0: combinational normalize + round of the incoming product
    fpm_norm_round u_norm_round (
        .sign      (bus.in_sign),
        .exp_sum   (bus.in_exp),
        .mant_prod (bus.in_mant),
        .nan       (bus.in_nan),
        .inf       (bus.in_inf),
        .zero      (bus.in_zero),
        .s1        (norm_p0)
    );

    assign s2_adv      = !vld_p2 || bus.out_ready;
    assign s1_adv      = !vld_p1 || s2_adv;
    assign bus.in_ready = s1_adv;

    // ---- stage 1: rounded bundle register
    always_ff @(posedge clk) begin
        if (s1_adv && bus.in_valid) begin
            s1_p1 <= norm_p0;
        end
    end

    // ---- stage 2: packed result register, valids for both stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            res_p2 <= '0;
            ovf_p2 <= 1'b0;
            unf_p2 <= 1'b0;
        end else begin
            if (s1_adv) begin
                vld_p1 <= bus.in_valid;
            end
            if (s2_adv) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    {ovf_p2, unf_p2, res_p2} <= pack_result(s1_p1);
                end
            end
        end
    end

    assign bus.out_valid  = vld_p2;
    assign bus.out_result = res_p2;
    assign bus.out_ovf    = ovf_p2;
    assign bus.out_unf    = unf_p2;

endmodule

// File: tb/tb_fpm_result_pack.sv
// Directed bench for fpm_result_pack: scoreboard of expected packed results,
// checked with immediate assertions whenever the stage presents an output.
`timescale 1ns/1ps
module tb_fpm_result_pack;
    import fpm_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpm_result_pack_if bus ();

    fpm_result_pack dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   tests = 0;
    int   fails = 0;

`ifdef FPM_ROUND_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    localparam logic [9:0] E127 = 10'(FPM_BIAS);

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] req);
        tests++;
        assert (got === req) else begin
            fails++;
            $error("FAIL %s got %h required %h", tag, got, req);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic req);
        tests++;
        assert (got === req) else begin
            fails++;
            $error("FAIL %s got %b required %b", tag, got, req);
        end
    endtask

    task automatic drive(input logic sg, input logic [9:0] e, input logic [47:0] p,
                         input logic z, input logic inf, input logic nan);
        bus.in_sign = sg;
        bus.in_exp  = e;
        bus.in_mant = p;
        bus.in_zero = z;
        bus.in_inf  = inf;
        bus.in_nan  = nan;
    endtask

    task automatic push(input string tag, input logic [31:0] res, input logic ovf, input logic unf);
        exp_t x;
        x.res = res;
        x.ovf = ovf;
        x.unf = unf;
        x.tag = tag;
        exp_q.push_back(x);
    endtask

    task automatic send(input string tag, input logic sg, input logic [9:0] e, input logic [47:0] p,
                        input logic z, input logic inf, input logic nan,
                        input logic [31:0] res, input logic ovf, input logic unf);
        int n;
        drive(sg, e, p, z, inf, nan);
        bus.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk1({tag, "_in_ready"}, bus.in_ready, 1'b1);
        if (bus.in_ready === 1'b1) push(tag, res, ovf, unf);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        tests++;
        assert (exp_q.size() == 0) else begin
            fails++;
            $error("FAIL %s_drain got %0d pending required 0", tag, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Output side: every presented result must match the scoreboard head,
    // including every cycle it is held under backpressure.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_output got %h required none", bus.out_result);
            end
            if (exp_q.size() != 0) begin
                cur = exp_q[0];
                tests++;
                assert (bus.out_result === cur.res) else begin
                    fails++;
                    $error("FAIL %s result got %h required %h", cur.tag, bus.out_result, cur.res);
                end
                tests++;
                assert (bus.out_ovf === cur.ovf) else begin
                    fails++;
                    $error("FAIL %s ovf got %b required %b", cur.tag, bus.out_ovf, cur.ovf);
                end
                tests++;
                assert (bus.out_unf === cur.unf) else begin
                    fails++;
                    $error("FAIL %s unf got %b required %b", cur.tag, bus.out_unf, cur.unf);
                end
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired with %0d pending required 0", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 10'd0, 48'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk32("rst_out_result", bus.out_result, 32'h0);
        chk1("rst_out_ovf", bus.out_ovf, 1'b0);
        chk1("rst_out_unf", bus.out_unf, 1'b0);
        chk1("rst_in_ready", bus.in_ready, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // normal, rounding, range and special cases, streamed back to back
        send("basic", 1'b0, E127, 48'h900000000000, 1'b0, 1'b0, 1'b0, 32'h40100000, 1'b0, 1'b0);
        send("basic_neg", 1'b1, E127, 48'h900000000000, 1'b0, 1'b0, 1'b0, 32'hC0100000, 1'b0, 1'b0);
        send("tie_even", 1'b0, E127, 48'h400000400000, 1'b0, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0);
        send("tie_odd", 1'b0, E127, 48'h400000C00000, 1'b0, 1'b0, 1'b0,
             RNE ? 32'h3F800002 : 32'h3F800001, 1'b0, 1'b0);
        send("carry_out", 1'b0, E127, 48'h7FFFFFC00000, 1'b0, 1'b0, 1'b0,
             RNE ? 32'h40000000 : 32'h3FFFFFFF, 1'b0, 1'b0);
        send("ovf", 1'b0, 10'd254, 48'h800000000000, 1'b0, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b0);
        send("carry_ovf", 1'b0, 10'd254, 48'h7FFFFFC00000, 1'b0, 1'b0, 1'b0,
             RNE ? 32'h7F800000 : 32'h7F7FFFFF, RNE, 1'b0);
        send("max_exp", 1'b0, 10'd254, 48'h400000000000, 1'b0, 1'b0, 1'b0, 32'h7F000000, 1'b0, 1'b0);
        send("unf", 1'b1, 10'd0, 48'h400000000000, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        send("min_exp", 1'b0, 10'd1, 48'h400000000000, 1'b0, 1'b0, 1'b0, 32'h00800000, 1'b0, 1'b0);
        send("neg_exp", 1'b0, 10'h3FB, 48'h900000000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1);
        send("nan_inf", 1'b1, E127, 48'h900000000000, 1'b0, 1'b1, 1'b1, 32'h7FC00000, 1'b0, 1'b0);
        send("inf_neg", 1'b1, E127, 48'h900000000000, 1'b0, 1'b1, 1'b0, 32'hFF800000, 1'b0, 1'b0);
        send("zero", 1'b0, E127, 48'h900000000000, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0);
        send("zero_over_ovf", 1'b1, 10'd254, 48'h800000000000, 1'b1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0);
        drain("main");

        // backpressure: two bundles fill the pipe, the third is held off
        bus.out_ready = 1'b0;
        send("bp_a", 1'b0, E127, 48'h900000000000, 1'b0, 1'b0, 1'b0, 32'h40100000, 1'b0, 1'b0);
        send("bp_b", 1'b1, E127, 48'h900000000000, 1'b0, 1'b0, 1'b0, 32'hC0100000, 1'b0, 1'b0);
        drive(1'b0, 10'd128, 48'h800000000000, 1'b0, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("bp_c_blocked", bus.in_ready, 1'b0);
            chk1("bp_held_valid", bus.out_valid, 1'b1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk1("bp_c_accept", bus.in_ready, 1'b1);
        if (bus.in_ready === 1'b1) push("bp_c", 32'h40800000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk1("bp_b_next_cycle", bus.out_valid, 1'b1);
        @(negedge clk);
        chk1("bp_c_next_cycle", bus.out_valid, 1'b1);
        @(negedge clk);
        chk1("bp_empty", bus.out_valid, 1'b0);
        drain("bp");

        // asynchronous reset with two bundles in flight
        bus.out_ready = 1'b0;
        send("rst_a", 1'b0, E127, 48'h900000000000, 1'b0, 1'b0, 1'b0, 32'h40100000, 1'b0, 1'b0);
        send("rst_b", 1'b0, 10'd254, 48'h800000000000, 1'b0, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk1("mid_rst_out_valid", bus.out_valid, 1'b0);
        chk32("mid_rst_out_result", bus.out_result, 32'h0);
        chk1("mid_rst_in_ready", bus.in_ready, 1'b1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("post_rst_no_stale", bus.out_valid, 1'b0);
            chk1("post_rst_in_ready", bus.in_ready, 1'b1);
        end
        @(posedge clk);
        #1;
        send("post_rst", 1'b0, E127, 48'h400000C00000, 1'b0, 1'b0, 1'b0,
             RNE ? 32'h3F800002 : 32'h3F800001, 1'b0, 1'b0);
        drain("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
